// File: rtl/sm_mult_sched_if.sv
// rtl/sm_mult_sched_if.sv - requester/consumer handshake bundle for sm_mult_sched
interface sm_mult_sched_if #(
    parameter int WIDTH = 4
);
    localparam int PW = 2*WIDTH-1;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [PW-1:0]    res_p;
    logic             res_id;
    logic             busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_p, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_p, res_id, busy
    );
endinterface

// File: rtl/sm_mult_sched.sv
// rtl/sm_mult_sched.sv - round-robin scheduler sharing one sign-magnitude shift-add multiplier
// Optional macro SM_SCHED_ZERO_SKIP_EN: zero-magnitude operands bypass MUL and finish next cycle.
module sm_mult_sched #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    sm_mult_sched_if.slave bus
);
    localparam int MW = WIDTH-1;
    localparam int AW = 2*MW;
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic           id_q, id_d;
    logic           sign_q, sign_d;
    logic [AW-1:0]  a_sh_q, a_sh_d;
    logic [MW-1:0]  b_sh_q, b_sh_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic             any_valid;
    logic             grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             done;

    // rr_q names the preferred requester; it only matters when both are valid.
    assign any_valid = bus.req0_valid | bus.req1_valid;
    assign grant     = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
    assign sel_a     = grant ? bus.req1_a : bus.req0_a;
    assign sel_b     = grant ? bus.req1_b : bus.req0_b;
    assign done      = (state_q == DONE);

    assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid && grant;
    assign bus.res_valid  = done;
    assign bus.res_p      = done ? {sign_q && (acc_q != '0), acc_q} : '0;
    assign bus.res_id     = done & id_q;
    assign bus.busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        sign_d  = sign_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_sh_d  = {{(AW-MW){1'b0}}, sel_a[MW-1:0]};
                    b_sh_d  = sel_b[MW-1:0];
                    sign_d  = sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
                    id_d    = grant;
                    acc_d   = '0;
                    cnt_d   = '0;
                    rr_d    = ~grant;
                    state_d = MUL;
`ifdef SM_SCHED_ZERO_SKIP_EN
                    if ((sel_a[MW-1:0] == '0) || (sel_b[MW-1:0] == '0)) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            MUL: begin
                // Multiplicand shifts left while multiplier shifts right: bit cnt lines up with a<<cnt.
                if (b_sh_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(MW-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            sign_q  <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            sign_q  <= sign_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_sm_mult_sched.sv
// tb/tb_sm_mult_sched.sv - directed self-checking bench for sm_mult_sched
module tb_sm_mult_sched;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sm_mult_sched_if #(.WIDTH(4)) bus ();

    sm_mult_sched #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SM_SCHED_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 4;
`endif

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_res(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 20);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        checks++;
        if (bus.res_p !== 7'b0000000) begin errors++; $display("FAIL reset_res_p got %b want 0000000", bus.res_p); end
        checks++;
        if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id got %b want 0", bus.res_id); end
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", {bus.req0_ready, bus.req1_ready});
        end
    endtask

    task automatic test_single();
        int n;
        bit busy_ok;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.req0_a = 4'b0001;
        bus.req0_b = 4'b1011;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", bus.req0_ready); end
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end while (!bus.res_valid && n < 20);
        checks++;
        if (n != 4) begin errors++; $display("FAIL single_latency got %0d want 4", n); end
        checks++;
        if (!busy_ok) begin errors++; $display("FAIL single_busy got low want high"); end
        checks++;
        if (bus.res_p !== 7'b1000011) begin errors++; $display("FAIL single_p got %b want 1000011", bus.res_p); end
        checks++;
        if (bus.res_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", bus.res_id); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if ({bus.res_valid, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL single_release got %b want 00", {bus.res_valid, bus.busy});
        end
    endtask

    task automatic test_contention();
        int n;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b1111; bus.req0_b = 4'b1111;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b1001; bus.req1_b = 4'b1111;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL cont_grant0 got %b want 10", {bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        wait_res(n);
        checks++;
        if (bus.res_p !== 7'b0110001 || bus.res_id !== 1'b0) begin
            errors++; $display("FAIL cont_res0 got %b/%b want 0110001/0", bus.res_p, bus.res_id);
        end
        checks++;
        if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_ready_in_done got %b want 0", bus.req1_ready); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL cont_grant1 got %b want 01", {bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        wait_res(n);
        checks++;
        if (bus.res_p !== 7'b0000111 || bus.res_id !== 1'b1) begin
            errors++; $display("FAIL cont_res1 got %b/%b want 0000111/1", bus.res_p, bus.res_id);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int n;
        logic [6:0] exp_p;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b1111; bus.req0_b = 4'b0111;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0010; bus.req1_b = 4'b0111;
        bus.res_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_res(n);
            exp_p = (i % 2 == 0) ? 7'b1110001 : 7'b0001110;
            checks++;
            if (bus.res_id !== 1'(i % 2)) begin
                errors++; $display("FAIL fair_id[%0d] got %b want %0d", i, bus.res_id, i % 2);
            end
            checks++;
            if (bus.res_p !== exp_p) begin
                errors++; $display("FAIL fair_p[%0d] got %b want %b", i, bus.res_p, exp_p);
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_neg_zero();
        int n;
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_a = 4'b1000; bus.req1_b = 4'b0011;
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        wait_res(n);
        checks++;
        if (n != ZERO_LAT) begin errors++; $display("FAIL negzero_latency got %0d want %0d", n, ZERO_LAT); end
        checks++;
        if (bus.res_p !== 7'b0000000 || bus.res_id !== 1'b1) begin
            errors++; $display("FAIL negzero_res got %b/%b want 0000000/1", bus.res_p, bus.res_id);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        bit stable;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0001; bus.req0_b = 4'b1011;
        @(posedge clk);
        #1;
        bus.req0_a = 4'b0010; bus.req0_b = 4'b0011;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0011; bus.req1_b = 4'b1010;
        wait_res(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_p !== 7'b1000011 || bus.res_id !== 1'b0 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_hold got unstable want stable res and readies low"); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checks++;
        if ({bus.res_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_release got %b want 001", {bus.res_valid, bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk);
        #1 bus.req1_valid = 1'b0; bus.req0_valid = 1'b0;
        wait_res(n);
        checks++;
        if (bus.res_p !== 7'b1000110 || bus.res_id !== 1'b1) begin
            errors++; $display("FAIL bp_next got %b/%b want 1000110/1", bus.res_p, bus.res_id);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n;
        bit leaked;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0011; bus.req0_b = 4'b0011;
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.res_valid} !== 2'b00 || bus.res_p !== 7'b0000000) begin
            errors++; $display("FAIL midrst_state got %b/%b want 00/0000000", {bus.busy, bus.res_valid}, bus.res_p);
        end
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked) begin errors++; $display("FAIL midrst_leak got activity want none"); end
        bus.req0_valid = 1'b1; bus.req0_a = 4'b0011; bus.req0_b = 4'b0011;
        bus.req1_valid = 1'b1; bus.req1_a = 4'b0010; bus.req1_b = 4'b0010;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL midrst_grant got %b want 10", {bus.req0_ready, bus.req1_ready});
        end
        @(posedge clk);
        #1 bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        wait_res(n);
        checks++;
        if (n != 4 || bus.res_p !== 7'b0001001 || bus.res_id !== 1'b0) begin
            errors++; $display("FAIL midrst_after got %0d/%b/%b want 4/0001001/0", n, bus.res_p, bus.res_id);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_neg_zero();
        test_backpressure();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sm_mult_sched.md
Name: sm_mult_sched

Overview:
- Round-robin scheduler that shares one sign-magnitude shift-add multiplier between two requesters.
- Owns the multiplier sequencing: operand capture, one multiplier bit per cycle (LSB-first), sign resolution, and result hold until the consumer accepts it.
- Sits in front of the serial-multiplier datapath. Operand/product format matches that datapath: MSB is the sign, the remaining bits are the magnitude.

Parameters:
- WIDTH, 4, operand width including sign bit (magnitude is WIDTH-1 bits); product width PW = 2*WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  WIDTH  requester 0 multiplicand (sign-magnitude).
- req0_b  in  WIDTH  requester 0 multiplier (sign-magnitude).
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- res_valid  out  1  product available.
- res_ready  in  1  consumer accepts product.
- res_p  out  PW  product (sign-magnitude).
- res_id  out  1  requester that owns res_p.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: res_valid=0, res_p=0, res_id=0, busy=0, reqN_ready=0, state=IDLE, rr pointer = requester 0 preferred.
- Handshake: a transfer occurs when valid && ready in the same cycle. Requesters hold a/b stable while valid && !ready.
- State IDLE:
  - reqN_ready is combinational: state==IDLE && grant==N.
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not served last (rr pointer).
  - On a transfer: capture a_mag, b_mag, sign = a[WIDTH-1]^b[WIDTH-1] and id; clear the accumulator; flip the rr pointer to prefer the other requester; go to MUL.
  - No valid requester: stay in IDLE.
- State MUL: exactly WIDTH-1 cycles, driven by a bit counter 0..WIDTH-2.
  - Each cycle: if b_mag[cnt] is set, acc += a_mag << cnt.
  - acc is 2*(WIDTH-1) bits and cannot overflow.
  - After the last bit, go to DONE.
- State DONE:
  - res_valid=1, res_p = {sign_eff, acc}, res_id = captured id.
  - sign_eff = sign && (acc != 0). A zero product is always positive, so negative zero is never output.
  - res_p and res_id hold stable while res_ready=0.
  - On res_ready: res_valid falls next cycle and state goes to IDLE.
- Latency: transfer in cycle T; res_valid high from cycle T+WIDTH (T+4 for the default).
- Throughput: next transfer no earlier than the cycle after the result handshake. No reqN_ready is asserted outside IDLE.
- Simultaneous events:
  - Both requesters valid in the same cycle: exactly one ready is asserted.
  - A requester that stays valid wins the next IDLE cycle if the other requester was served last.
  - A requester dropping valid while not granted is legal and has no effect.
- Reset mid-operation (MUL or DONE): the next cycle is IDLE with all outputs at reset values. The in-flight product is discarded and never reported.
- Operands with magnitude 0 (including sign-set zero 1000) take the full MUL sequence and yield 0000000.

Optional Feature:
- Macro SM_SCHED_ZERO_SKIP_EN.
- Defined: at the transfer, if a_mag==0 or b_mag==0, skip MUL and go straight to DONE with acc=0. res_valid is then high at T+1. Non-zero operands keep the T+WIDTH latency.
- Undefined: every operation takes T+WIDTH. Results are identical either way; only latency differs.

Test Plan:
- Single request: req0 A=0001, B=1011 (1 * -3) -> res_p=1000011, res_id=0, res_valid exactly 4 cycles after the req0 transfer; busy high throughout.
- Contention after reset: req0 1111*1111 and req1 1001*1111 both valid in the same cycle -> req0 granted first, res_p=0110001 id=0; then req1, res_p=0000111 id=1.
- Fairness: both requesters held valid for 6 operations (res_ready=1) -> grants alternate 0,1,0,1,0,1. Check 1111*0111 -> 1110001 and 0010*0111 -> 0001110.
- Negative zero: req1 1000*0011 -> res_p=0000000, id=1. Latency 4 without SM_SCHED_ZERO_SKIP_EN, 1 with it.
- Backpressure: res_ready=0 for 5 cycles in DONE with req0 and req1 valid -> res_valid, res_p, res_id stable and both readies low. Release res_ready -> IDLE next cycle, then the next grant.
- Reset in the 2nd MUL cycle -> next cycle busy=0, res_valid=0, res_p=0. No result appears; a subsequent request completes normally with req0 preferred.
